// File: rtl/ddr_cmn_zqcal_seq.sv
// ZQ calibration sequencer: successive-approximation search of the pull-up code
// (pcal) and then the pull-down code (ncal) against the analog ZQ comparator.
// Registered outputs; a result takes 2*CODE_W*(settle+NSAMP+2)+2 cycles from start.
// No backpressure: i_start is taken only in IDLE, and i_abort restores the backup codes.
//
// Ports:
//   i_clk, i_rst              clock and asynchronous active-high reset
//   i_start, i_abort          start request (IDLE only) and abort (non-IDLE only)
//   i_settle_cnt              wait cycles after each code change (program >= 2)
//   i_zqcal_comp              asynchronous comparator output, 1 = code too low
//   o_cal_ena, o_pd_sel       analog enable and phase select (0 pull-up, 1 pull-down)
//   o_pcal, o_ncal            codes driven to the analog macro
//   o_busy, o_done            run in progress, one-cycle completion pulse
//   o_pcal_sat, o_ncal_sat    final code hit all-0 or all-1
module ddr_cmn_zqcal_seq #(
    parameter int CODE_W   = 5,
    parameter int VOTE_W   = 2,
    parameter int SETTLE_W = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [SETTLE_W-1:0] i_settle_cnt,
    input  logic                i_zqcal_comp,
    output logic                o_cal_ena,
    output logic                o_pd_sel,
    output logic [CODE_W-1:0]   o_pcal,
    output logic [CODE_W-1:0]   o_ncal,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_pcal_sat,
    output logic                o_ncal_sat
);

    localparam int NSAMP = 1 << VOTE_W;
    localparam int BIT_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam logic [VOTE_W:0]  HALF    = (VOTE_W + 1)'(NSAMP / 2);
    localparam logic [VOTE_W:0]  LAST    = (VOTE_W + 1)'(NSAMP - 1);
    localparam logic [BIT_W-1:0] TOP_BIT = BIT_W'(CODE_W - 1);

    typedef enum logic [2:0] {IDLE, SET, SETTLE, SAMPLE, DECIDE, DONE} state_t;

    state_t              state_q, state_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [CODE_W-1:0]   working_q, working_d;
    logic [CODE_W-1:0]   bkp_pcal_q, bkp_pcal_d;
    logic [CODE_W-1:0]   bkp_ncal_q, bkp_ncal_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [VOTE_W:0]     smp_q, smp_d;
    logic [VOTE_W:0]     ones_q, ones_d;
    logic                sync1_q, sync2_q;
    logic                cal_ena_q, cal_ena_d;
    logic                pd_sel_q, pd_sel_d;
    logic [CODE_W-1:0]   pcal_q, pcal_d;
    logic [CODE_W-1:0]   ncal_q, ncal_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                psat_q, psat_d;
    logic                nsat_q, nsat_d;

    logic [CODE_W-1:0]   mask;
    logic [CODE_W-1:0]   trial;
    logic [CODE_W-1:0]   new_w;
    logic                decision;
    logic                new_sat;

    // Two-flop synchroniser for the asynchronous comparator.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= i_zqcal_comp;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            bit_q      <= '0;
            working_q  <= '0;
            bkp_pcal_q <= '0;
            bkp_ncal_q <= '0;
            settle_q   <= '0;
            smp_q      <= '0;
            ones_q     <= '0;
            cal_ena_q  <= 1'b0;
            pd_sel_q   <= 1'b0;
            pcal_q     <= '0;
            ncal_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            psat_q     <= 1'b0;
            nsat_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            working_q  <= working_d;
            bkp_pcal_q <= bkp_pcal_d;
            bkp_ncal_q <= bkp_ncal_d;
            settle_q   <= settle_d;
            smp_q      <= smp_d;
            ones_q     <= ones_d;
            cal_ena_q  <= cal_ena_d;
            pd_sel_q   <= pd_sel_d;
            pcal_q     <= pcal_d;
            ncal_q     <= ncal_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            psat_q     <= psat_d;
            nsat_q     <= nsat_d;
        end
    end

    // SAR arithmetic is set/clear of the current bit only, so codes never wrap.
    assign mask     = CODE_W'(1) << bit_q;
    assign trial    = working_q | mask;
    assign decision = (ones_q >= HALF);             // a tie keeps the bit
    assign new_w    = decision ? trial : (working_q & ~mask);
    assign new_sat  = (new_w == '0) || (new_w == '1);

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        working_d  = working_q;
        bkp_pcal_d = bkp_pcal_q;
        bkp_ncal_d = bkp_ncal_q;
        settle_d   = settle_q;
        smp_d      = smp_q;
        ones_d     = ones_q;
        cal_ena_d  = cal_ena_q;
        pd_sel_d   = pd_sel_q;
        pcal_d     = pcal_q;
        ncal_d     = ncal_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        psat_d     = psat_q;
        nsat_d     = nsat_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    bkp_pcal_d = pcal_q;
                    bkp_ncal_d = ncal_q;
                    psat_d     = 1'b0;
                    nsat_d     = 1'b0;
                    working_d  = '0;
                    bit_d      = TOP_BIT;
                    pd_sel_d   = 1'b0;
                    cal_ena_d  = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = SET;
                end
            end
            SET: begin
                if (pd_sel_q) ncal_d = trial;
                else          pcal_d = trial;
                ones_d   = '0;
                smp_d    = '0;
                settle_d = i_settle_cnt;
                state_d  = (i_settle_cnt == '0) ? SAMPLE : SETTLE;
            end
            SETTLE: begin
                // Entered with the programmed count; one cycle per count value.
                if (settle_q <= SETTLE_W'(1)) state_d = SAMPLE;
                else                          settle_d = settle_q - 1'b1;
            end
            SAMPLE: begin
                ones_d = ones_q + {{VOTE_W{1'b0}}, sync2_q};
                smp_d  = smp_q + 1'b1;
                if (smp_q == LAST) state_d = DECIDE;
            end
            DECIDE: begin
                working_d = new_w;
                if (pd_sel_q) ncal_d = new_w;
                else          pcal_d = new_w;
                if (bit_q != '0) begin
                    bit_d   = bit_q - 1'b1;
                    state_d = SET;
                end else if (!pd_sel_q) begin
                    psat_d    = new_sat;
                    pd_sel_d  = 1'b1;
                    working_d = '0;
                    bit_d     = TOP_BIT;
                    state_d   = SET;
                end else begin
                    nsat_d  = new_sat;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d    = 1'b1;
                busy_d    = 1'b0;
                cal_ena_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over whatever the state above decided this cycle.
        if (i_abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            pcal_d    = bkp_pcal_q;
            ncal_d    = bkp_ncal_q;
            cal_ena_d = 1'b0;
            busy_d    = 1'b0;
            pd_sel_d  = 1'b0;
            done_d    = 1'b0;
            psat_d    = 1'b0;
            nsat_d    = 1'b0;
        end
    end

    assign o_cal_ena  = cal_ena_q;
    assign o_pd_sel   = pd_sel_q;
    assign o_pcal     = pcal_q;
    assign o_ncal     = ncal_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_pcal_sat = psat_q;
    assign o_ncal_sat = nsat_q;

endmodule
